adc_frame_averager: RTL and testbench
=====================================

// Module: adc_frame_averager
// PURPOSE
//  Multi-channel successor to the single-channel ADC compressor. Averages 2**AVG_LOG2 consecutive
//  samples per pixel on N_CH ADC channels in lockstep, with a programmable inter-pixel gap and
//  pixel count. Adds optional rounding, saturation, frame-done/frame-error flags and a pixel index.
//  Sits between the ADC deserialiser/aligner and the pixel packer, in the ADC frame-clock domain.
// PARAMETERS
//  N_CH        4     number of ADC channels processed in parallel
//  DW          14    ADC sample width, also output width per channel
//  AVG_LOG2    3     log2 of samples averaged per pixel (1..6)
//  GAP_CYCLES  11    idle cycles between pixels (>=1)
//  PIXELS      5184  pixels per frame (1..65535)
//  ROUND       0     0 = truncate (floor); 1 = round half up
// PORTS
//  ad_fco_clk       in   1         ADC frame clock; the only clock
//  reset_n          in   1         synchronous reset, active low
//  marker_a         in   1         first-pixel marker from the readout sequencer
//  data_aligned     in   1         aligner lock; must stay high for the whole frame
//  adc_data         in   N_CH*DW   channel c at bits [c*DW +: DW]
//  data_valid       out  1         1-cycle pulse: compressed_data/pixel_index valid
//  compressed_data  out  N_CH*DW   per-channel average, same packing as adc_data
//  pixel_index      out  16        0-based index of the pixel on compressed_data
//  frame_done       out  1         1-cycle pulse after the last pixel is output
//  frame_err        out  1         1-cycle pulse when a frame is aborted (alignment lost)
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge): state=IDLE; all outputs 0; accumulators/counters 0. Reset
//   takes effect mid-frame without emitting valid, done or err.
//  FSM, one-hot: IDLE, SUM, DIV, GAP.
//   IDLE: marker_a & data_aligned -> SUM. marker_a outside IDLE is ignored.
//   SUM: adds adc_data into each lane on every SUM cycle (first sample = cycle after marker).
//    After exactly 2**AVG_LOG2 SUM cycles -> DIV.
//   DIV: lane result registered. data_valid=1 and pixel_index=current count in the cycle after
//    DIV. Pixel counter then increments. Accumulators clear.
//   GAP: lasts GAP_CYCLES cycles. Then -> SUM if pixels output < PIXELS.
//    Otherwise -> IDLE, with frame_done=1 in the first IDLE cycle.
//   Pixel period = 2**AVG_LOG2 + 1 + GAP_CYCLES cycles (20 at defaults).
//  Abort: data_aligned=0 in any non-IDLE state -> IDLE next cycle, frame_err=1 that cycle.
//   A pixel whose DIV has not yet occurred is never output. data_valid of a pixel already in
//   DIV is still emitted.
//  Arithmetic per lane: unsigned accumulator, DW+AVG_LOG2 bits, no overflow possible.
//   ROUND=0: out = acc >> AVG_LOG2.
//   ROUND=1: out = (acc + 2**(AVG_LOG2-1)) >> AVG_LOG2, computed with 1 extra bit and saturated
//   to 2**DW-1.
//  compressed_data and pixel_index hold their value between valid pulses and in IDLE.
//  data_valid and frame_done never assert in the same cycle. frame_done follows the last valid
//   by GAP_CYCLES+1 cycles.
// STRUCTURE
//  Package adc_avg_pkg: state encoding localparams, ACC_W=DW+AVG_LOG2 function,
//   pixel counter width (16).
//  Sub-module adc_avg_lane (accumulate / clear / divide / round / saturate for one channel),
//   instantiated N_CH times by generate. FSM and counters live in the top module.
//  Registered outputs only; no combinational path from input to output.
// TESTING
//  1 Defaults, all channels constant 1000, marker_a+aligned -> 5184 data_valid pulses.
//    Period 20 cycles, every lane 1000, pixel_index 0..5183, one frame_done 12 cycles after
//    the last valid.
//  2 Ch0 samples 0,0,0,0,0,0,0,7 (sum 7): ROUND=0 -> 0; ROUND=1 -> 1. Ch1 per-sample ramp
//    0..7 (sum 28) -> ROUND=0 3, ROUND=1 4.
//  3 ROUND=1, all samples 16383 -> output 16383 (saturated, not wrapped to 0).
//  4 Drop data_aligned during SUM of pixel 10 -> exactly 10 valids (index 0..9),
//    frame_err 1 cycle, no frame_done. A new marker then restarts at index 0.
//  5 reset_n=0 for 1 cycle mid-GAP -> all outputs 0 next cycle, no valid. marker_a pulses
//    mid-frame have no effect.
//  6 N_CH=1, AVG_LOG2=2, GAP_CYCLES=1, PIXELS=3 -> 3 valids spaced 6 cycles, then frame_done.

Source files
------------

// File: rtl/adc_avg_pkg.sv
// adc_avg_pkg
//   Shared definitions for the ADC frame averager: one-hot state encoding,
//   accumulator width helper and counter widths.
//   No ports.
package adc_avg_pkg;

  // Width of the pixel counter and of pixel_index.
  localparam int PIX_W = 16;
  // Width of the shared sample/gap cycle counter.
  localparam int CNT_W = 16;

  // One-hot sequencer states.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SUM  = 4'b0010,
    ST_DIV  = 4'b0100,
    ST_GAP  = 4'b1000
  } state_e;

  // Accumulator width needed to sum 2**avg_log2 samples of dw bits without overflow.
  function automatic int acc_w(input int dw, input int avg_log2);
    return dw + avg_log2;
  endfunction

endpackage

// File: rtl/adc_avg_lane.sv
// adc_avg_lane
//   One averaging lane: accumulates samples, then divides by 2**AVG_LOG2
//   (truncate or round-half-up with saturation) into a held result register.
// Ports
//   clk     in   1    clock
//   rst_n   in   1    synchronous reset, active low
//   clr     in   1    clear accumulator
//   add_en  in   1    add sample into accumulator
//   div_en  in   1    register divided result and clear accumulator
//   sample  in   DW   input sample
//   result  out  DW   averaged result, held between div_en pulses
module adc_avg_lane
  import adc_avg_pkg::*;
#(
  parameter int DW       = 14,
  parameter int AVG_LOG2 = 3,
  parameter int ROUND    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          add_en,
  input  logic          div_en,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] result
);

  localparam int ACC_W = acc_w(DW, AVG_LOG2);
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(2**(AVG_LOG2-1));

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DW-1:0]    res_q, res_d;
  logic [ACC_W:0]   rnd_sum;
  logic [DW:0]      rnd_shift;
  logic [DW-1:0]    div_val;

  always_comb begin
    // Rounding uses one extra bit; the top bit of the shifted value flags saturation.
    rnd_sum   = {1'b0, acc_q} + HALF;
    rnd_shift = rnd_sum[ACC_W:AVG_LOG2];
    if (ROUND != 0) begin
      div_val = rnd_shift[DW] ? {DW{1'b1}} : rnd_shift[DW-1:0];
    end else begin
      div_val = acc_q[ACC_W-1:AVG_LOG2];
    end

    acc_d = acc_q;
    if (clr || div_en) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(sample);
    end

    res_d = div_en ? div_val : res_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/adc_frame_averager.sv
// adc_frame_averager
//   Averages 2**AVG_LOG2 consecutive samples per pixel on N_CH channels in
//   lockstep, with GAP_CYCLES idle cycles between pixels and PIXELS pixels per
//   frame. Flags frame completion and alignment-loss aborts.
// Ports
//   ad_fco_clk       in   1        ADC frame clock
//   reset_n          in   1        synchronous reset, active low
//   marker_a         in   1        first-pixel marker (only honoured in IDLE)
//   data_aligned     in   1        aligner lock; loss aborts the frame
//   adc_data         in   N_CH*DW  channel c at [c*DW +: DW]
//   data_valid       out  1        pulse: compressed_data/pixel_index valid
//   compressed_data  out  N_CH*DW  per-channel averages
//   pixel_index      out  16       0-based pixel index
//   frame_done       out  1        pulse after the last pixel of a frame
//   frame_err        out  1        pulse when a frame is aborted
module adc_frame_averager
  import adc_avg_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DW         = 14,
  parameter int AVG_LOG2   = 3,
  parameter int GAP_CYCLES = 11,
  parameter int PIXELS     = 5184,
  parameter int ROUND      = 0
) (
  input  logic                 ad_fco_clk,
  input  logic                 reset_n,
  input  logic                 marker_a,
  input  logic                 data_aligned,
  input  logic [N_CH*DW-1:0]   adc_data,
  output logic                 data_valid,
  output logic [N_CH*DW-1:0]   compressed_data,
  output logic [PIX_W-1:0]     pixel_index,
  output logic                 frame_done,
  output logic                 frame_err
);

  localparam logic [CNT_W-1:0] SUM_LAST = CNT_W'(2**AVG_LOG2 - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] pixel_index_q, pixel_index_d;
  logic             last_q, last_d;
  logic             done_pend_q, done_pend_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lane_clr, lane_add, lane_div;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_index_d = pixel_index_q;
    last_d        = last_q;
    done_pend_d   = done_pend_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    lane_clr      = (state_q == ST_IDLE);
    lane_add      = (state_q == ST_SUM);
    // A pixel that has reached DIV is always completed, even if alignment drops now.
    lane_div      = (state_q == ST_DIV);
    valid_d       = lane_div;

    case (state_q)
      ST_IDLE: begin
        // frame_done is raised from the first IDLE cycle, so it lands one cycle later.
        done_d      = done_pend_q;
        done_pend_d = 1'b0;
        if (marker_a && data_aligned) begin
          state_d   = ST_SUM;
          cnt_d     = '0;
          pix_cnt_d = '0;
          last_d    = 1'b0;
        end
      end
      ST_SUM: begin
        if (cnt_q == SUM_LAST) begin
          state_d = ST_DIV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIV: begin
        state_d       = ST_GAP;
        cnt_d         = '0;
        pixel_index_d = pix_cnt_q;
        pix_cnt_d     = pix_cnt_q + PIX_W'(1);
        last_d        = (pix_cnt_q == PIX_LAST);
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (last_q) begin
            state_d     = ST_IDLE;
            done_pend_d = 1'b1;
          end else begin
            state_d = ST_SUM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loss of alignment overrides any state transition outside IDLE.
    if ((state_q != ST_IDLE) && !data_aligned) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      done_pend_d = 1'b0;
      err_d       = 1'b1;
    end
  end

  always_ff @(posedge ad_fco_clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pix_cnt_q     <= '0;
      pixel_index_q <= '0;
      last_q        <= 1'b0;
      done_pend_q   <= 1'b0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_index_q <= pixel_index_d;
      last_q        <= last_d;
      done_pend_q   <= done_pend_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
    adc_avg_lane #(
      .DW       (DW),
      .AVG_LOG2 (AVG_LOG2),
      .ROUND    (ROUND)
    ) u_lane (
      .clk    (ad_fco_clk),
      .rst_n  (reset_n),
      .clr    (lane_clr),
      .add_en (lane_add),
      .div_en (lane_div),
      .sample (adc_data[gi*DW +: DW]),
      .result (compressed_data[gi*DW +: DW])
    );
  end

  assign data_valid  = valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_adc_frame_averager.sv
// Bench for adc_frame_averager. Two 4-channel instances (truncate / round)
// share one stimulus stream; a third small 1-channel instance covers short
// frames. Expected pixels are queued by the stimulus and checked by monitors.
module tb_adc_frame_averager;

  localparam int NA   = 4;
  localparam int DW   = 14;
  localparam int PA   = 12;   // pixels per frame for the 4-channel instances
  localparam int NS_A = 8;    // samples per pixel
  localparam int PERA = 20;   // pixel period, 4-channel instances
  localparam int GA   = 11;
  localparam int PB   = 3;
  localparam int NS_B = 4;
  localparam int PERB = 6;
  localparam int GB   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, mk_a, al_a, mk_b, al_b;
  logic [NA*DW-1:0] data_a;
  logic [DW-1:0]    data_b;
  logic             v0, v1, v2, fd0, fd1, fd2, fe0, fe1, fe2;
  logic [NA*DW-1:0] cd0, cd1;
  logic [DW-1:0]    cd2;
  logic [15:0]      pi0, pi1, pi2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int               idx;
    logic [NA*DW-1:0] e0;
    logic [NA*DW-1:0] e1;
  } exp_a_t;
  typedef struct {
    int            idx;
    logic [DW-1:0] e;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  int exp_done_a = 0, exp_err_a = 0, exp_done_b = 0;
  int seen_done0 = 0, seen_done1 = 0, seen_err0 = 0, seen_err1 = 0;
  int seen_done2 = 0, seen_err2 = 0;
  int cyc_a = 0, last_v_a = 0, cyc_b = 0, last_v_b = 0;

  adc_frame_averager #(.N_CH(NA), .DW(DW), .AVG_LOG2(3), .GAP_CYCLES(GA), .PIXELS(PA), .ROUND(0)) u_dut0 (
    .ad_fco_clk(clk), .reset_n(reset_n), .marker_a(mk_a), .data_aligned(al_a), .adc_data(data_a),
    .data_valid(v0), .compressed_data(cd0), .pixel_index(pi0), .frame_done(fd0), .frame_err(fe0));

  adc_frame_averager #(.N_CH(NA), .DW(DW), .AVG_LOG2(3), .GAP_CYCLES(GA), .PIXELS(PA), .ROUND(1)) u_dut1 (
    .ad_fco_clk(clk), .reset_n(reset_n), .marker_a(mk_a), .data_aligned(al_a), .adc_data(data_a),
    .data_valid(v1), .compressed_data(cd1), .pixel_index(pi1), .frame_done(fd1), .frame_err(fe1));

  adc_frame_averager #(.N_CH(1), .DW(DW), .AVG_LOG2(2), .GAP_CYCLES(GB), .PIXELS(PB), .ROUND(1)) u_dut2 (
    .ad_fco_clk(clk), .reset_n(reset_n), .marker_a(mk_b), .data_aligned(al_b), .adc_data(data_b),
    .data_valid(v2), .compressed_data(cd2), .pixel_index(pi2), .frame_done(fd2), .frame_err(fe2));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference average: plain integer arithmetic on the sample sum.
  function automatic logic [DW-1:0] avg(input int sum, input int n, input bit rnd);
    int r;
    r = rnd ? (sum + n / 2) / n : sum / n;
    if (r > 16383) r = 16383;
    return DW'(r);
  endfunction

  // mode 0 random, 1 constant 1000, 2 ch0 spike / ch1 ramp, 3 full scale
  function automatic logic [DW-1:0] smp(input int mode, input int ch, input int s);
    case (mode)
      1: return DW'(1000);
      2: begin
        if (ch == 0) return (s == 7) ? DW'(7) : DW'(0);
        else if (ch == 1) return DW'(s);
        else return DW'($urandom_range(0, 16383));
      end
      3: return DW'(16383);
      default: return DW'($urandom_range(0, 16383));
    endcase
  endfunction

  function automatic logic [NA*DW-1:0] rnd_a();
    logic [NA*DW-1:0] d;
    for (int ch = 0; ch < NA; ch++) d[ch*DW +: DW] = DW'($urandom_range(0, 16383));
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_a = rnd_a();
      data_b = DW'($urandom_range(0, 16383));
    end
  endtask

  // One frame on the 4-channel pair. ab_p/ab_c: drop alignment at pixel/cycle;
  // rs_p/rs_c: pulse reset at pixel/cycle (cycle 0..7 SUM, 8 DIV, 9..19 GAP).
  task automatic frame_a(input int mode, input int ab_p, input int ab_c,
                         input int rs_p, input int rs_c, input bit noise);
    int            sums[NA];
    logic [DW-1:0] v;
    exp_a_t        e;
    @(negedge clk);
    mk_a   = 1'b1;
    al_a   = 1'b1;
    data_a = rnd_a();
    for (int p = 0; p < PA; p++) begin
      for (int ch = 0; ch < NA; ch++) sums[ch] = 0;
      for (int c = 0; c < PERA; c++) begin
        @(negedge clk);
        mk_a   = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        data_a = rnd_a();
        if (c < NS_A) begin
          for (int ch = 0; ch < NA; ch++) begin
            v = smp(mode, ch, c);
            data_a[ch*DW +: DW] = v;
            sums[ch] += int'(v);
          end
        end
        if (c == NS_A) begin
          e.idx = p;
          for (int ch = 0; ch < NA; ch++) begin
            e.e0[ch*DW +: DW] = avg(sums[ch], NS_A, 1'b0);
            e.e1[ch*DW +: DW] = avg(sums[ch], NS_A, 1'b1);
          end
          qa.push_back(e);
        end
        if (p == ab_p && c == ab_c) begin
          al_a = 1'b0;
          mk_a = 1'b0;
          @(posedge clk);
          #1;
          chk("abort_err0", fe0, 1);
          chk("abort_err1", fe1, 1);
          exp_err_a++;
          @(negedge clk);
          al_a = 1'b1;
          return;
        end
        if (p == rs_p && c == rs_c) begin
          reset_n = 1'b0;
          mk_a    = 1'b0;
          @(posedge clk);
          #1;
          chk("rst_valid0", v0, 0);   chk("rst_valid1", v1, 0);
          chk("rst_data0", cd0, 0);   chk("rst_data1", cd1, 0);
          chk("rst_index0", pi0, 0);  chk("rst_index1", pi1, 0);
          chk("rst_done0", fd0, 0);   chk("rst_err0", fe0, 0);
          @(negedge clk);
          reset_n = 1'b1;
          return;
        end
      end
    end
    exp_done_a++;
    @(negedge clk);
    mk_a = 1'b0;
  endtask

  task automatic frame_b(input int mode);
    int            sum;
    logic [DW-1:0] v;
    exp_b_t        e;
    @(negedge clk);
    mk_b = 1'b1;
    al_b = 1'b1;
    for (int p = 0; p < PB; p++) begin
      sum = 0;
      for (int c = 0; c < PERB; c++) begin
        @(negedge clk);
        mk_b   = 1'b0;
        data_b = DW'($urandom_range(0, 16383));
        if (c < NS_B) begin
          v      = (mode == 3) ? DW'(16383) : DW'($urandom_range(0, 16383));
          data_b = v;
          sum   += int'(v);
        end
        if (c == NS_B) begin
          e.idx = p;
          e.e   = avg(sum, NS_B, 1'b1);
          qb.push_back(e);
        end
      end
    end
    exp_done_b++;
  endtask

  // Monitor for the 4-channel pair.
  always @(negedge clk) begin
    exp_a_t e;
    cyc_a++;
    if (v0 || v1) begin
      chk("valid0", v0, 1);
      chk("valid1", v1, 1);
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_a: index=%0d expected no pixel", pi0);
      end else begin
        e = qa.pop_front();
        chk("index0", pi0, e.idx);
        chk("index1", pi1, e.idx);
        chk("data_trunc", cd0, e.e0);
        chk("data_round", cd1, e.e1);
        if (e.idx != 0) chk("period_a", cyc_a - last_v_a, PERA);
      end
      last_v_a = cyc_a;
    end
    if (fd0) begin
      seen_done0++;
      chk("done_delay_a", cyc_a - last_v_a, GA + 1);
      chk("done_not_valid", v0, 0);
    end
    if (fd1) seen_done1++;
    if (fe0) seen_err0++;
    if (fe1) seen_err1++;
  end

  // Monitor for the 1-channel instance.
  always @(negedge clk) begin
    exp_b_t e;
    cyc_b++;
    if (v2) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_b: index=%0d expected no pixel", pi2);
      end else begin
        e = qb.pop_front();
        chk("index_b", pi2, e.idx);
        chk("data_b", cd2, e.e);
        if (e.idx != 0) chk("period_b", cyc_b - last_v_b, PERB);
      end
      last_v_b = cyc_b;
    end
    if (fd2) begin
      seen_done2++;
      chk("done_delay_b", cyc_b - last_v_b, GB + 1);
    end
    if (fe2) seen_err2++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    mk_a = 1'b0; al_a = 1'b1; data_a = '0;
    mk_b = 1'b0; al_b = 1'b1; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", v0, 0);
    chk("reset_data", cd1, 0);
    chk("reset_index", pi0, 0);
    chk("reset_done", fd0, 0);
    chk("reset_err", fe1, 0);
    chk("reset_valid_b", v2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    frame_a(1, -1, -1, -1, -1, 1'b0); idle(20);   // constant 1000
    frame_a(2, -1, -1, -1, -1, 1'b0); idle(20);   // spike / ramp rounding cases
    frame_a(3, -1, -1, -1, -1, 1'b0); idle(20);   // full scale
    frame_a(0, -1, -1, -1, -1, 1'b1); idle(20);   // random data, stray markers
    frame_a(0, 10, 3, -1, -1, 1'b0);  idle(20);   // abort in SUM of pixel 10
    frame_a(0, -1, -1, -1, -1, 1'b0); idle(20);   // restart from index 0
    frame_a(0, 5, 8, -1, -1, 1'b0);   idle(20);   // abort during DIV keeps pixel 5
    frame_a(0, 2, 15, -1, -1, 1'b0);  idle(20);   // abort during GAP
    frame_a(0, -1, -1, 4, 14, 1'b1);  idle(20);   // reset mid-GAP
    frame_a(0, -1, -1, -1, -1, 1'b0); idle(20);

    frame_b(0); idle(10);
    frame_b(3); idle(10);

    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);
    chk("done_count0", seen_done0, exp_done_a);
    chk("done_count1", seen_done1, exp_done_a);
    chk("err_count0", seen_err0, exp_err_a);
    chk("err_count1", seen_err1, exp_err_a);
    chk("done_count_b", seen_done2, exp_done_b);
    chk("err_count_b", seen_err2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
